// File: rtl/snake_pkg.sv
// Shared definitions for the snake tick controller: state codes, direction codes, defaults.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package snake_pkg;

    localparam int TICK_DIV_DEF   = 50000;
    localparam int TICK_MIN_DEF   = 10000;
    localparam int SPEED_STEP_DEF = 2000;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN       = 3'd1,
        ST_WAIT_HEAD = 3'd2,
        ST_ITEM      = 3'd3,
        ST_PAUSED    = 3'd4,
        ST_OVER      = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    // Opposite directions share the axis bit (bit1) and differ in bit0.
    function automatic logic is_reverse(input dir_t a, input dir_t b);
        return (a[1] == b[1]) && (a[0] != b[0]);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/snake_dir_latch.sv
// Button priority encoder plus pending-direction register with reversal rejection.
// Latency: pending direction updates on the edge after the press is sampled.
// Backpressure: none; presses while disabled are dropped.
//
// Ports: clk, rst (sync, active-high); push[3:0] active-low buttons;
//        load forces pending to the pressed button (game start, no reversal check);
//        enable allows normal updates; dir_now is the committed direction;
//        press_vld/press_dir expose the encoded press; dir_pend is the pending direction.
module snake_dir_latch
    import snake_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] push,
    input  logic       load,
    input  logic       enable,
    input  dir_t       dir_now,
    output logic       press_vld,
    output dir_t       press_dir,
    output dir_t       dir_pend
);

    // Lowest button index wins when several are held.
    always_comb begin
        press_vld = ~(&push);
        press_dir = DIR_RIGHT;
        if (!push[0])      press_dir = DIR_UP;
        else if (!push[1]) press_dir = DIR_DOWN;
        else if (!push[2]) press_dir = DIR_LEFT;
        else               press_dir = DIR_RIGHT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dir_pend <= DIR_RIGHT;
        end else if (load && press_vld) begin
            dir_pend <= press_dir;
        end else if (enable && press_vld && !is_reverse(press_dir, dir_now)) begin
            // The winning button is dropped outright if it reverses; lower
            // priority buttons held at the same time do not get a turn.
            dir_pend <= press_dir;
        end
    end

endmodule

// File: rtl/snake_tick_ctrl.sv
// Snake game sequencer: move tick generation, head/item handshakes, pause, game over.
// Latency: o_Move TICK_DIV cycles after start/resume of a tick; all outputs registered.
// Backpressure: no new o_Move until i_HeadDone; o_ItemReq held until i_ItemAck.
//
// Optional feature macro: SNAKE_SPEEDUP_EN (tick period shrinks by SPEED_STEP per eat,
// floor TICK_MIN, restored on o_Clear). Without it the period is the constant TICK_DIV.
//
// Ports: Clk, Rst (sync, active-high); i_Push[3:0] active-low up/down/left/right;
//        i_Pause level; i_HeadDone pulse qualifying i_Hit/i_Eat; i_ItemAck;
//        o_Move, o_Clear strobes; o_Dir committed direction; o_ItemReq level;
//        o_State FSM code; o_Score items eaten (saturating).
module snake_tick_ctrl
    import snake_pkg::*;
#(
    parameter int TICK_DIV   = TICK_DIV_DEF,
    parameter int TICK_MIN   = TICK_MIN_DEF,
    parameter int SPEED_STEP = SPEED_STEP_DEF
)
(
    input  logic       Clk,
    input  logic       Rst,
    input  logic [3:0] i_Push,
    input  logic       i_Pause,
    input  logic       i_HeadDone,
    input  logic       i_Hit,
    input  logic       i_Eat,
    input  logic       i_ItemAck,
    output logic       o_Move,
    output logic [1:0] o_Dir,
    output logic       o_ItemReq,
    output logic       o_Clear,
    output logic [2:0] o_State,
    output logic [7:0] o_Score
);

    // Wide enough for the period and for the clamp threshold TICK_MIN+SPEED_STEP.
    localparam int CW = $clog2(max_int(TICK_DIV, TICK_MIN + SPEED_STEP) + 1);

    state_t          state;
    dir_t            dir_q;
    logic [CW-1:0]   cnt;
    logic            rel_seen;   // in OVER: all buttons have been seen released

    logic            press_vld;
    dir_t            press_dir;
    dir_t            dir_pend;

`ifdef SNAKE_SPEEDUP_EN
    logic [CW-1:0]   period;
`else
    logic [CW-1:0]   period;
    assign period = CW'(TICK_DIV);
`endif

    assign o_Dir   = dir_q;
    assign o_State = state;

    snake_dir_latch u_dir_latch (
        .clk       (Clk),
        .rst       (Rst),
        .push      (i_Push),
        .load      (state == ST_IDLE),
        .enable    (state != ST_OVER),
        .dir_now   (dir_q),
        .press_vld (press_vld),
        .press_dir (press_dir),
        .dir_pend  (dir_pend)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            dir_q     <= DIR_RIGHT;
            rel_seen  <= 1'b0;
            o_Move    <= 1'b0;
            o_Clear   <= 1'b0;
            o_ItemReq <= 1'b0;
            o_Score   <= 8'd0;
`ifdef SNAKE_SPEEDUP_EN
            period    <= CW'(TICK_DIV);
`endif
        end else begin
            o_Move  <= 1'b0;
            o_Clear <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (press_vld) begin
                        state   <= ST_RUN;
                        o_Clear <= 1'b1;
                        o_Score <= 8'd0;
                        dir_q   <= press_dir;
                        cnt     <= '0;
`ifdef SNAKE_SPEEDUP_EN
                        period  <= CW'(TICK_DIV);
`endif
                    end
                end

                ST_RUN: begin
                    if (i_Pause) begin
                        state <= ST_PAUSED;          // counter frozen
                    end else if (cnt == period - CW'(1)) begin
                        cnt    <= '0;
                        o_Move <= 1'b1;
                        dir_q  <= dir_pend;
                        state  <= ST_WAIT_HEAD;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                ST_WAIT_HEAD: begin
                    if (i_HeadDone) begin
                        if (i_Hit) begin
                            state    <= ST_OVER;
                            rel_seen <= 1'b0;
                        end else if (i_Eat) begin
                            state     <= ST_ITEM;
                            o_ItemReq <= 1'b1;
                            if (o_Score != 8'hFF) o_Score <= o_Score + 8'd1;
`ifdef SNAKE_SPEEDUP_EN
                            if (period >= CW'(TICK_MIN + SPEED_STEP))
                                period <= period - CW'(SPEED_STEP);
                            else
                                period <= CW'(TICK_MIN);
`endif
                        end else begin
                            state <= i_Pause ? ST_PAUSED : ST_RUN;
                        end
                    end
                end

                ST_ITEM: begin
                    if (i_ItemAck) begin
                        o_ItemReq <= 1'b0;
                        state     <= i_Pause ? ST_PAUSED : ST_RUN;
                    end
                end

                ST_PAUSED: begin
                    if (!i_Pause) state <= ST_RUN;
                end

                ST_OVER: begin
                    // A button still held from play must be released before
                    // a fresh press can leave the game-over screen.
                    if (!rel_seen) begin
                        if (&i_Push) rel_seen <= 1'b1;
                    end else if (press_vld) begin
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/snake_tick_ctrl.md
SNAKE_TICK_CTRL -- requirements
Module: snake_tick_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50000: Clk cycles per move tick.
REQ-002 Parameter TICK_MIN, default 10000: minimum tick period (speed-up floor).
REQ-003 Parameter SPEED_STEP, default 2000: period reduction per item eaten.
REQ-004 Clk  in  1  single system clock; all logic on rising edge.
REQ-005 Rst  in  1  reset; synchronous, active-high.
REQ-006 i_Push  in  4  buttons, active-low; bit0=up, bit1=down, bit2=left, bit3=right.
REQ-007 i_Pause  in  1  level pause request, active-high.
REQ-008 i_HeadDone  in  1  one-cycle pulse from the head datapath: move result valid.
REQ-009 i_Hit  in  1  collision flag; qualified by i_HeadDone.
REQ-010 i_Eat  in  1  item-eaten flag; qualified by i_HeadDone.
REQ-011 i_ItemAck  in  1  item generator has placed the new item.
REQ-012 o_Move  out  1  one-cycle strobe: advance snake one cell.
REQ-013 o_Dir  out  2  committed direction: 0=up, 1=down, 2=left, 3=right.
REQ-014 o_ItemReq  out  1  request for a new item position; held until acknowledged.
REQ-015 o_Clear  out  1  one-cycle strobe: re-initialise snake and board.
REQ-016 o_State  out  3  current FSM state code.
REQ-017 o_Score  out  8  items eaten in the current game.

Function
REQ-018 States SHALL be IDLE=0, RUN=1, WAIT_HEAD=2, ITEM=3, PAUSED=4, OVER=5.
REQ-019 IDLE -> RUN on any i_Push bit low: pulse o_Clear, clear o_Score, load o_Dir from the pressed button, clear the tick counter.
REQ-020 RUN: the tick counter SHALL increment each cycle; at period-1 it wraps to 0, pulses o_Move, and the FSM enters WAIT_HEAD.
REQ-021 o_Dir SHALL update only in the o_Move cycle, from the pending direction register.
REQ-022 Pending direction: set on a button press in any state except OVER; priority bit0 > bit1 > bit2 > bit3; a press reversing the committed o_Dir (up/down, left/right) SHALL be ignored.
REQ-023 WAIT_HEAD on i_HeadDone: if i_Hit -> OVER (Hit has priority over Eat); else if i_Eat -> ITEM with o_Score incremented (saturates at 255); else -> RUN.
REQ-024 ITEM: o_ItemReq SHALL be high for the whole state; on i_ItemAck it drops in the same cycle as the transition to RUN.
REQ-025 Pause: i_Pause high in RUN -> PAUSED with the tick counter frozen. In WAIT_HEAD or ITEM the transaction completes first, then the FSM enters PAUSED instead of RUN.
REQ-026 PAUSED -> RUN when i_Pause is low; the counter resumes from its frozen value.
REQ-027 OVER: outputs hold. Exit to IDLE only after all buttons have been seen released and then a button is pressed.
REQ-028 o_Move and o_Clear SHALL never be high in the same cycle. o_Move SHALL not pulse again before i_HeadDone has been received.

Reset
REQ-029 While Rst is high, the next edge sets: state IDLE, counter 0, o_Dir=3, pending=3, o_Score=0, o_Move=0, o_ItemReq=0, o_Clear=0, speed period=TICK_DIV.
REQ-030 Rst mid-transaction (WAIT_HEAD/ITEM) SHALL abandon the handshake with no further strobe.

Configuration
REQ-031 Macro SNAKE_SPEEDUP_EN defined: each eat reduces the tick period by SPEED_STEP, clamped at TICK_MIN; the period returns to TICK_DIV on o_Clear.
REQ-032 Macro absent: the period is fixed at TICK_DIV and the speed register is not synthesised.

Structure
REQ-033 A shared package snake_pkg SHALL hold the state codes, direction codes and the default TICK_DIV/TICK_MIN/SPEED_STEP constants.
REQ-034 One sub-module, snake_dir_latch, SHALL hold button priority encoding, reversal rejection and the pending-direction register.

Verification
REQ-035 Reset, then i_Push=4'b1110 -> o_Clear pulse, o_State=RUN, o_Dir=0; first o_Move exactly TICK_DIV cycles later.
REQ-036 o_Dir=0, press down (4'b1101) -> ignored; press left (4'b1011) -> o_Dir=2 in the next o_Move cycle only.
REQ-037 i_HeadDone with i_Eat=1 -> o_Score+1, o_ItemReq high until i_ItemAck, then RUN; with SNAKE_SPEEDUP_EN the next tick interval is TICK_DIV-2000.
REQ-038 i_Pause=1 in WAIT_HEAD -> after i_HeadDone enter PAUSED, no o_Move for 10000 cycles; release -> the remaining count completes.
REQ-039 i_HeadDone with i_Hit=1 and i_Eat=1 -> OVER, score unchanged; hold a button -> stays OVER; release then press -> IDLE.
REQ-040 o_Score at 255 plus an eat -> stays 255.
